mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter onto a single shared
// request/address/data bus, with anti-starvation for fetches and misalignment trapping.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ok,
  output logic        data_err,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stall
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t          state_q;
  owner_t          owner_q;
  logic [CW-1:0]   starve_q;
  logic [CW-1:0]   starve_d;
  logic            inst_win_s;
  logic            data_win_s;

  logic            bus_req_q;
  logic            bus_wr_q;
  logic [31:0]     bus_addr_q;
  logic [3:0]      bus_wstrb_q;
  logic [31:0]     bus_wdata_q;
  logic [31:0]     inst_rdata_q;
  logic [31:0]     data_rdata_q;
  logic            inst_ok_q;
  logic            data_ok_q;
  logic            data_err_q;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = a[0];
      2'd2:    bad = (a != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] strobes(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << a;
      2'd1:    s = 4'b0011 << {a[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lanes(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{w[7:0]}};
      2'd1:    r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  // Grant decision and starvation counter next state; a fetch wins once data has won LIMIT times in a row
  always_comb begin
    inst_win_s = 1'b0;
    data_win_s = 1'b0;
    if (state_q == IDLE) begin
      if (inst_req && (!data_req || (starve_q == LIMIT_C))) begin
        inst_win_s = 1'b1;
      end else if (data_req) begin
        data_win_s = 1'b1;
      end else begin
        inst_win_s = 1'b0;
      end
    end else begin
      data_win_s = 1'b0;
    end

    starve_d = starve_q;
    if (!inst_req || inst_win_s) begin
      starve_d = '0;
    end else if (data_win_s && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + CW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Transaction FSM with all bus-facing and requester-facing outputs registered
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      starve_q     <= '0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_addr_q   <= 32'h0000_0000;
      bus_wstrb_q  <= 4'b0000;
      bus_wdata_q  <= 32'h0000_0000;
      inst_rdata_q <= 32'h0000_0000;
      data_rdata_q <= 32'h0000_0000;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      data_err_q   <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      inst_ok_q  <= 1'b0;
      data_ok_q  <= 1'b0;
      data_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_win_s) begin
            owner_q <= OWN_DATA;
            if (misaligned(data_size, data_addr[1:0])) begin
              // Bad access is answered locally; the bus never sees it
              state_q    <= ERR;
              data_ok_q  <= 1'b1;
              data_err_q <= 1'b1;
            end else begin
              state_q     <= ADDR;
              bus_req_q   <= 1'b1;
              bus_wr_q    <= data_wr;
              bus_addr_q  <= data_addr;
              bus_wstrb_q <= data_wr ? strobes(data_size, data_addr[1:0]) : 4'b0000;
              bus_wdata_q <= lanes(data_size, data_wdata);
            end
          end else if (inst_win_s) begin
            owner_q     <= OWN_INST;
            state_q     <= ADDR;
            bus_req_q   <= 1'b1;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= inst_addr;
            bus_wstrb_q <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
          end else begin
            state_q <= IDLE;
          end
        end
        ADDR: begin
          if (bus_addr_ok) begin
            state_q   <= WAIT;
            bus_req_q <= 1'b0;
          end else begin
            state_q <= ADDR;
          end
        end
        WAIT: begin
          if (bus_data_ok) begin
            state_q <= IDLE;
            if (owner_q == OWN_DATA) begin
              data_rdata_q <= bus_rdata;
              data_ok_q    <= 1'b1;
            end else begin
              inst_rdata_q <= bus_rdata;
              inst_ok_q    <= 1'b1;
            end
          end else begin
            state_q <= WAIT;
          end
        end
        ERR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_wr     = bus_wr_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_wdata  = bus_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign inst_ok    = inst_ok_q;
  assign data_rdata = data_rdata_q;
  assign data_ok    = data_ok_q;
  assign data_err   = data_err_q;

  // Held low while in reset so every output reads zero during reset
  assign stall = resetn & ((inst_req & ~inst_ok_q) | (data_req & ~data_ok_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: loads, stores, error trapping,
// fetch anti-starvation ordering and asynchronous reset mid-transaction.
module tb_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        data_err;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stall;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .inst_ok     (inst_ok),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_ok     (data_ok),
    .data_err    (data_err),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_order [6];
  int          n;

  initial begin
    resetn      = 1'b0;
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;

    step();
    step();
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("rst_inst_ok", {31'd0, inst_ok}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
    resetn = 1'b1;
    step();

    // Load word 0x100, bus answers immediately
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h100;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
    step();
    chk("lw_bus_req", {31'd0, bus_req}, 32'd1);
    chk("lw_bus_addr", bus_addr, 32'h100);
    chk("lw_bus_wr", {31'd0, bus_wr}, 32'd0);
    chk("lw_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("lw_stall", {31'd0, stall}, 32'd1);
    chk("lw_early_ok", {31'd0, data_ok}, 32'd0);
    step();
    chk("lw_wait_req", {31'd0, bus_req}, 32'd0);
    chk("lw_wait_ok", {31'd0, data_ok}, 32'd0);
    step();
    chk("lw_ok", {31'd0, data_ok}, 32'd1);
    chk("lw_rdata", data_rdata, 32'hDEADBEEF);
    chk("lw_err", {31'd0, data_err}, 32'd0);
    chk("lw_inst_ok", {31'd0, inst_ok}, 32'd0);
    chk("lw_stall_off", {31'd0, stall}, 32'd0);
    data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    step();
    chk("lw_ok_pulse", {31'd0, data_ok}, 32'd0);
    chk("lw_idle_req", {31'd0, bus_req}, 32'd0);

    // Store byte 0x203, ADDR held two cycles, inputs scrambled after latching
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h203; data_wdata = 32'h000000A5;
    step();
    chk("sb_req", {31'd0, bus_req}, 32'd1);
    chk("sb_wr", {31'd0, bus_wr}, 32'd1);
    chk("sb_wstrb", {28'd0, bus_wstrb}, 32'h8);
    chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
    chk("sb_addr", bus_addr, 32'h203);
    data_addr = 32'h0; data_wdata = 32'hFFFFFFFF; data_size = 2'd2; data_wr = 1'b0;
    step();
    chk("sb_hold_req", {31'd0, bus_req}, 32'd1);
    chk("sb_hold_addr", bus_addr, 32'h203);
    chk("sb_hold_wdata", bus_wdata, 32'hA5A5A5A5);
    chk("sb_hold_wstrb", {28'd0, bus_wstrb}, 32'h8);
    chk("sb_hold_wr", {31'd0, bus_wr}, 32'd1);
    bus_addr_ok = 1'b1;
    step();
    chk("sb_wait_req", {31'd0, bus_req}, 32'd0);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h12345678;
    step();
    chk("sb_ok", {31'd0, data_ok}, 32'd1);
    chk("sb_err", {31'd0, data_err}, 32'd0);
    chk("sb_rdata", data_rdata, 32'h12345678);
    data_req = 1'b0; bus_data_ok = 1'b0;
    step();

    // Store half 0x202 (aligned, upper lanes)
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h202; data_wdata = 32'h0000BEEF;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    step();
    chk("sh_wstrb", {28'd0, bus_wstrb}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hBEEFBEEF);
    step();
    step();
    chk("sh_ok", {31'd0, data_ok}, 32'd1);
    data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    step();

    // Store half 0x201 is misaligned: ERR for one cycle, no bus request
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h201;
    step();
    chk("sh_mis_ok", {31'd0, data_ok}, 32'd1);
    chk("sh_mis_err", {31'd0, data_err}, 32'd1);
    chk("sh_mis_req", {31'd0, bus_req}, 32'd0);
    data_req = 1'b0;
    step();
    chk("sh_mis_ok_pulse", {31'd0, data_ok}, 32'd0);
    chk("sh_mis_err_pulse", {31'd0, data_err}, 32'd0);
    chk("sh_mis_req_after", {31'd0, bus_req}, 32'd0);

    // Reserved size and misaligned word
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd3; data_addr = 32'h100;
    step();
    chk("rsv_err", {31'd0, data_err}, 32'd1);
    chk("rsv_req", {31'd0, bus_req}, 32'd0);
    data_req = 1'b0;
    step();
    data_req = 1'b1; data_size = 2'd2; data_addr = 32'h102;
    step();
    chk("lw_mis_err", {31'd0, data_err}, 32'd1);
    chk("lw_mis_ok", {31'd0, data_ok}, 32'd1);
    data_req = 1'b0;
    step();

    // Both requesters held: expect D,D,D,D,I,D
    exp_order[0] = 32'h800; exp_order[1] = 32'h800; exp_order[2] = 32'h800;
    exp_order[3] = 32'h800; exp_order[4] = 32'h4000; exp_order[5] = 32'h800;
    inst_req = 1'b1; inst_addr = 32'h4000;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h800;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h55AA55AA;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (bus_req !== 1'b1 && n < 8) begin
        step();
        chk("no_dual_ok", {31'd0, inst_ok & data_ok}, 32'd0);
        n++;
      end
      chk("grant_timeout", {31'd0, (n < 8)}, 32'd1);
      chk($sformatf("grant_%0d", g), bus_addr, exp_order[g]);
      step();
    end
    chk("starve_inst_rdata", inst_rdata, 32'h55AA55AA);
    inst_req = 1'b0; data_req = 1'b0;
    step();
    chk("starve_last_ok", {31'd0, data_ok}, 32'd1);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    step();

    // Simultaneous requests straight out of reset: data first, then fetch
    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h4000;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h800;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h11112222;
    #1;
    chk("sim_rst_stall", {31'd0, stall}, 32'd0);
    chk("sim_rst_req", {31'd0, bus_req}, 32'd0);
    step();
    resetn = 1'b1;
    step();
    chk("sim_first_addr", bus_addr, 32'h800);
    chk("sim_first_req", {31'd0, bus_req}, 32'd1);
    chk("sim_stall1", {31'd0, stall}, 32'd1);
    step();
    chk("sim_stall2", {31'd0, stall}, 32'd1);
    step();
    chk("sim_data_ok", {31'd0, data_ok}, 32'd1);
    chk("sim_inst_ok_early", {31'd0, inst_ok}, 32'd0);
    chk("sim_data_rdata", data_rdata, 32'h11112222);
    data_req = 1'b0; bus_rdata = 32'h33334444;
    step();
    chk("sim_inst_addr", bus_addr, 32'h4000);
    chk("sim_inst_req", {31'd0, bus_req}, 32'd1);
    chk("sim_stall3", {31'd0, stall}, 32'd1);
    step();
    step();
    chk("sim_inst_ok", {31'd0, inst_ok}, 32'd1);
    chk("sim_inst_rdata", inst_rdata, 32'h33334444);
    chk("sim_data_ok_off", {31'd0, data_ok}, 32'd0);
    chk("sim_stall_off", {31'd0, stall}, 32'd0);
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    step();

    // Reset while a fetch sits in WAIT, then the still-pending fetch reruns
    inst_req = 1'b1; inst_addr = 32'h4000; bus_addr_ok = 1'b1; bus_data_ok = 1'b0; bus_rdata = 32'hCAFEF00D;
    step();
    chk("rw_addr_req", {31'd0, bus_req}, 32'd1);
    step();
    chk("rw_wait_req", {31'd0, bus_req}, 32'd0);
    chk("rw_wait_addr", bus_addr, 32'h4000);
    resetn = 1'b0;
    #1;
    chk("rw_rst_addr", bus_addr, 32'h0);
    chk("rw_rst_req", {31'd0, bus_req}, 32'd0);
    chk("rw_rst_ok", {31'd0, inst_ok}, 32'd0);
    chk("rw_rst_stall", {31'd0, stall}, 32'd0);
    bus_data_ok = 1'b1;
    step();
    chk("rw_rst_ignored", {31'd0, inst_ok}, 32'd0);
    resetn = 1'b1;
    step();
    chk("rw_rearb_req", {31'd0, bus_req}, 32'd1);
    chk("rw_rearb_addr", bus_addr, 32'h4000);
    step();
    step();
    chk("rw_inst_ok", {31'd0, inst_ok}, 32'd1);
    chk("rw_inst_rdata", inst_rdata, 32'hCAFEF00D);
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    step();
    chk("rw_inst_ok_pulse", {31'd0, inst_ok}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
